// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM states, oversampling constants and parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int OVS        = 16;
    localparam int MID_SAMPLE = 7;

    // Parity bit a correct transmitter sends for the given XOR of the data bits.
    function automatic logic parity_expected(input logic data_xor, input logic odd_n_even);
        return data_xor ^ odd_n_even;
    endfunction

endpackage

// File: rtl/uart_sync_bit.sv
// Single-bit multi-flop synchronizer for an asynchronous input; resets to 1 (idle line level).
module uart_sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '1;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_async.sv
// UART receiver with 16x oversampling, 7/8 data bits, optional parity and sticky error flags.
// Optional feature: UART_RX_GLITCH_FILTER_EN enables 2-of-3 majority sampling around mid-bit.
module uart_rx_async #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       baud_pulse,
    input  logic       rx,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       rd_byte,
    input  logic       clr_err,
    output logic [7:0] rx_byte,
    output logic       rx_rdy,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overflow
);

    import uart_pkg::*;

    localparam logic [3:0] CNT_LAST = 4'(OVS - 1);

    rx_state_t  state;
    rx_state_t  state_nxt;
    logic       rx_s;
    logic       sample;
    logic       decide;
    logic [3:0] cnt;
    logic [2:0] bit_idx;
    logic [2:0] last_idx;
    logic [7:0] shreg;
    logic       data_xor;
    logic       par_pend;
    logic       deliver;
    logic       start_det;
    logic       data_take;
    logic       data_last;
    logic       par_take;
    logic       stop_take;
    logic       accept;

    uart_sync_bit #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

`ifdef UART_RX_GLITCH_FILTER_EN
    // The counter keeps running through decisions, so the last majority tap doubles as the decision point.
    localparam logic [3:0] TAP0_CNT   = 4'(MID_SAMPLE);
    localparam logic [3:0] TAP1_CNT   = 4'(MID_SAMPLE + 1);
    localparam logic [3:0] DECIDE_CNT = 4'(MID_SAMPLE + 2);

    logic [1:0] hist;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist <= '0;
        end else if (baud_pulse) begin
            if (cnt == TAP0_CNT) hist[0] <= rx_s;
            if (cnt == TAP1_CNT) hist[1] <= rx_s;
        end
    end

    assign sample = (hist[0] & hist[1]) | (hist[0] & rx_s) | (hist[1] & rx_s);
`else
    localparam logic [3:0] DECIDE_CNT = 4'(MID_SAMPLE);

    assign sample = rx_s;
`endif

    assign decide   = baud_pulse && (cnt == DECIDE_CNT);
    assign last_idx = bit8 ? 3'd7 : 3'd6;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_det = 1'b0;
        data_take = 1'b0;
        data_last = 1'b0;
        par_take  = 1'b0;
        stop_take = 1'b0;
        case (state)
            IDLE: begin
                if (baud_pulse && !rx_s) begin
                    state_nxt = START;
                    start_det = 1'b1;
                end
            end
            START: begin
                if (decide) state_nxt = sample ? IDLE : DATA;
            end
            DATA: begin
                if (decide) begin
                    data_take = 1'b1;
                    if (bit_idx == last_idx) begin
                        data_last = 1'b1;
                        state_nxt = parity_en ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (decide) begin
                    par_take  = 1'b1;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (decide) begin
                    stop_take = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sample counter runs modulo 16 from the start-bit detection pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (start_det) begin
            cnt <= '0;
        end else if (baud_pulse && state != IDLE) begin
            cnt <= (cnt == CNT_LAST) ? 4'd0 : cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_idx  <= '0;
            shreg    <= '0;
            data_xor <= 1'b0;
            par_pend <= 1'b0;
            deliver  <= 1'b0;
        end else begin
            deliver <= stop_take;
            if (start_det) begin
                bit_idx  <= '0;
                data_xor <= 1'b0;
            end
            if (data_take) begin
                data_xor <= data_xor ^ sample;
                // In 7-bit mode the final shift also drops a 0 into bit 7.
                if (data_last && !bit8) begin
                    shreg <= {1'b0, sample, shreg[7:2]};
                end else begin
                    shreg <= {sample, shreg[7:1]};
                end
                if (data_last) begin
                    bit_idx  <= '0;
                    par_pend <= 1'b0;
                end else begin
                    bit_idx <= bit_idx + 3'd1;
                end
            end
            if (par_take) begin
                par_pend <= (sample != parity_expected(data_xor, odd_n_even));
            end
        end
    end

    assign accept = deliver && !(rx_rdy && !rd_byte);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_byte     <= '0;
            rx_rdy      <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (accept) begin
                rx_byte <= shreg;
                rx_rdy  <= 1'b1;
            end else if (rd_byte && !deliver) begin
                rx_rdy <= 1'b0;
            end

            if (accept && par_pend)          parity_err <= 1'b1;
            else if (clr_err)                parity_err <= 1'b0;

            if (stop_take && !sample)        framing_err <= 1'b1;
            else if (clr_err)                framing_err <= 1'b0;

            if (deliver && !accept)          overflow <= 1'b1;
            else if (clr_err)                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_async.sv
// Directed, table-driven bench for uart_rx_async with hand-computed frames and expectations.
module tb_uart_rx_async;

    import uart_pkg::*;

`ifdef UART_RX_GLITCH_FILTER_EN
    localparam int DEC = 10;
`else
    localparam int DEC = 8;
`endif

    logic       clk;
    logic       reset_n;
    logic       baud_pulse;
    logic       rx;
    logic       bit8;
    logic       parity_en;
    logic       odd_n_even;
    logic       rd_byte;
    logic       clr_err;
    logic [7:0] rx_byte;
    logic       rx_rdy;
    logic       parity_err;
    logic       framing_err;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_async #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .baud_pulse  (baud_pulse),
        .rx          (rx),
        .bit8        (bit8),
        .parity_en   (parity_en),
        .odd_n_even  (odd_n_even),
        .rd_byte     (rd_byte),
        .clr_err     (clr_err),
        .rx_byte     (rx_byte),
        .rx_rdy      (rx_rdy),
        .parity_err  (parity_err),
        .framing_err (framing_err),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rd_first;
        logic       clr_first;
        logic       b8;
        logic       pen;
        logic       odd;
        logic [7:0] data;
        logic       pbit;
        logic       sbit;
        logic [7:0] e_byte;
        logic       e_rdy;
        logic       e_perr;
        logic       e_ferr;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One baud slot: rx settles through the synchronizer before the pulse edge.
    task automatic tick(input logic v);
        rx = v;
        repeat (3) @(negedge clk);
        baud_pulse = 1'b1;
        @(negedge clk);
        baud_pulse = 1'b0;
    endtask

    task automatic send_bit(input logic v, input int glitch_slot);
        for (int k = 0; k < 16; k++) tick((k == glitch_slot) ? ~v : v);
    endtask

    task automatic pulse_rd();
        rd_byte = 1'b1;
        @(negedge clk);
        rd_byte = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic b8, input logic pen,
                              input logic odd, input logic pbit, input logic sbit,
                              input int glitch_bit, input logic rd_at_del,
                              output logic rdy0, output logic rdy1);
        bit8       = b8;
        parity_en  = pen;
        odd_n_even = odd;
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        for (int k = 0; k < 6; k++) tick(1'b1);
        send_bit(1'b0, -1);
        for (int i = 0; i < (b8 ? 8 : 7); i++) send_bit(d[i], (i == glitch_bit) ? 9 : -1);
        if (pen) send_bit(pbit, -1);
        for (int k = 0; k < 16; k++) begin
            tick(sbit);
            if (k == DEC) begin
                rdy0    = rx_rdy;
                rd_byte = rd_at_del;
                @(negedge clk);
                rd_byte = 1'b0;
                rdy1    = rx_rdy;
            end
        end
        rx = 1'b1;
    endtask

    initial begin
        logic r0, r1;

        reset_n    = 1'b0;
        baud_pulse = 1'b0;
        rx         = 1'b1;
        bit8       = 1'b1;
        parity_en  = 1'b0;
        odd_n_even = 1'b0;
        rd_byte    = 1'b0;
        clr_err    = 1'b0;

        //            rd    clr   b8    pen   odd   data   pbit  sbit  byte   rdy   perr  ferr  ovf
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h41, 1'b0, 1'b1, 8'h41, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h41, 1'b1, 1'b1, 8'h41, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h41, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h07, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1};

        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset rx_byte", 32'(rx_byte), 32'h00);
        check("reset rx_rdy", 32'(rx_rdy), 32'h0);
        check("reset parity_err", 32'(parity_err), 32'h0);
        check("reset framing_err", 32'(framing_err), 32'h0);
        check("reset overflow", 32'(overflow), 32'h0);
        check("reset state", 32'(dut.state), 32'(IDLE));

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].rd_first) pulse_rd();
            if (vecs[i].clr_first) pulse_clr();
            send_frame(vecs[i].data, vecs[i].b8, vecs[i].pen, vecs[i].odd, vecs[i].pbit,
                       vecs[i].sbit, -1, 1'b0, r0, r1);
            if (vecs[i].rd_first) begin
                check($sformatf("vec%0d rdy at stop sample", i), 32'(r0), 32'h0);
                check($sformatf("vec%0d rdy one clk later", i), 32'(r1), 32'h1);
            end
            check($sformatf("vec%0d rx_byte", i), 32'(rx_byte), 32'(vecs[i].e_byte));
            check($sformatf("vec%0d rx_rdy", i), 32'(rx_rdy), 32'(vecs[i].e_rdy));
            check($sformatf("vec%0d parity_err", i), 32'(parity_err), 32'(vecs[i].e_perr));
            check($sformatf("vec%0d framing_err", i), 32'(framing_err), 32'(vecs[i].e_ferr));
            check($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
        end

        // False start: 4-slot low pulse on an idle line.
        pulse_rd();
        pulse_clr();
        for (int k = 0; k < 6; k++) tick(1'b1);
        for (int k = 0; k < 4; k++) tick(1'b0);
        for (int k = 0; k < 14; k++) tick(1'b1);
        check("false start rx_rdy", 32'(rx_rdy), 32'h0);
        check("false start flags", 32'({parity_err, framing_err, overflow}), 32'h0);
        check("false start state", 32'(dut.state), 32'(IDLE));

        // rd_byte in the same clk as the second delivery.
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, r0, r1);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1, r0, r1);
        check("rd at delivery rx_byte", 32'(rx_byte), 32'h22);
        check("rd at delivery rx_rdy", 32'(rx_rdy), 32'h1);
        check("rd at delivery overflow", 32'(overflow), 32'h0);

        // Framing error then clr_err.
        pulse_rd();
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, r0, r1);
        check("framing set", 32'(framing_err), 32'h1);
        check("framing rx_byte", 32'(rx_byte), 32'h3C);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("framing cleared", 32'(framing_err), 32'h0);

        // Reset during data bit 3, then a clean frame.
        for (int k = 0; k < 20; k++) tick(1'b1);
        send_bit(1'b0, -1);
        for (int i = 0; i < 3; i++) send_bit(1'b0, -1);
        for (int k = 0; k < 5; k++) tick(1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("mid-frame reset rx_rdy", 32'(rx_rdy), 32'h0);
        for (int k = 0; k < 20; k++) tick(1'b1);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, r0, r1);
        check("after reset rx_byte", 32'(rx_byte), 32'h5A);
        check("after reset rx_rdy", 32'(rx_rdy), 32'h1);
        check("after reset overflow", 32'(overflow), 32'h0);
        check("after reset framing_err", 32'(framing_err), 32'h0);

        // One-slot glitch at counter value 8 of data bit 2.
        pulse_rd();
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0, r0, r1);
        check("glitch rx_byte", 32'(rx_byte), 32'h5A);
        check("glitch rx_rdy", 32'(rx_rdy), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
